// File: rtl/rs_hs_pkg.sv
// +--------------------------------------------------------------------+
// | rs_hs_pkg : shared state encoding and width helpers                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package rs_hs_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int src_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_hs_rr_pick.sv
// +--------------------------------------------------------------------+
// | rs_hs_rr_pick : rotate-priority encoder, first valid at/after ptr  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rs_hs_rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int SRC_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic [SRC_WIDTH-1:0] pick,
    output logic                 any_valid
);

    logic [SRC_WIDTH-1:0] idx;

    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = SRC_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_hs_pipeline_credit_arbiter.sv
// +--------------------------------------------------------------------+
// | rs_hs_pipeline_credit_arbiter : credit-gated packet round-robin    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rs_hs_pipeline_credit_arbiter
    import rs_hs_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDITS      = 24,
    parameter int CREDIT_WIDTH = credit_width(CREDITS),
    parameter int SRC_WIDTH    = src_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src,
    output logic                          out_last,
    input  logic                          credit_return,
    output logic [CREDIT_WIDTH-1:0]       credit_count,
    output logic                          credit_err,
    output logic                          idle
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(CREDITS);
    localparam logic [SRC_WIDTH-1:0]    LAST_IDX   = SRC_WIDTH'(NUM_REQ - 1);

    state_t                 state;
    logic [SRC_WIDTH-1:0]   ptr;
    logic [SRC_WIDTH-1:0]   grant;
    logic [SRC_WIDTH-1:0]   pick;
    logic [SRC_WIDTH-1:0]   sel;
    logic [SRC_WIDTH-1:0]   sel_next;
    logic                   any_valid;
    logic                   sel_active;
    logic                   accept;
    logic                   acc_last;
    logic [DATA_WIDTH-1:0]  acc_data;

    rs_hs_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // While locked the grantee keeps ready even between beats; others wait.
    always_comb begin
        sel        = (state == LOCKED) ? grant : pick;
        sel_active = (state == LOCKED) ? 1'b1 : any_valid;
        req_ready  = '0;
        if (reset && sel_active && (credit_count != '0)) begin
            req_ready[sel] = 1'b1;
        end
        accept   = |(req_valid & req_ready);
        acc_last = req_last[sel];
        acc_data = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        sel_next = (sel == LAST_IDX) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB;
            ptr          <= '0;
            grant        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_src      <= '0;
            out_last     <= 1'b0;
            credit_count <= CREDIT_MAX;
            credit_err   <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_data <= acc_data;
                out_src  <= sel;
                out_last <= acc_last;
                if (acc_last) begin
                    state <= ARB;
                    ptr   <= sel_next;
                end else begin
                    state <= LOCKED;
                    grant <= sel;
                end
            end

            // Simultaneous accept and return cancel out.
            case ({accept, credit_return})
                2'b10:   credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count == CREDIT_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_count <= credit_count + 1'b1;
                    end
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

    assign idle = (state == ARB) && (credit_count == CREDIT_MAX) && !out_valid;

endmodule

`default_nettype wire

// File: tb/tb_rs_hs_pipeline_credit_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_rs_hs_pipeline_credit_arbiter : directed vector bench           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rs_hs_pipeline_credit_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CR = 24;
    localparam int CW = 5;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_last;
    logic            credit_return;
    logic [CW-1:0]   credit_count;
    logic            credit_err;
    logic            idle;

    rs_hs_pipeline_credit_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .CREDITS    (CR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_last      (req_last),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_last      (out_last),
        .credit_return (credit_return),
        .credit_count  (credit_count),
        .credit_err    (credit_err),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         r;
        logic [N-1:0] er;
        logic         eov;
        logic [1:0]   esrc;
        logic         elast;
        int           ecnt;
        logic         eidle;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    function automatic logic [31:0] mk(input int i, input int t);
        return {16'hDA7A, 8'(t), 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic r, input logic [N-1:0] er, input logic eov,
                       input logic [1:0] esrc, input logic elast, input int ecnt,
                       input logic eidle);
        vec_t x;
        x.rst = rst; x.v = v; x.l = l; x.r = r; x.er = er; x.eov = eov;
        x.esrc = esrc; x.elast = elast; x.ecnt = ecnt; x.eidle = eidle;
        tbl.push_back(x);
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        req_valid     = '0;
        req_last      = '0;
        credit_return = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Called just after a rising edge: drive, check ready mid-cycle, check outputs after the edge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                        input logic [N-1:0] er, input logic eov, input logic [1:0] esrc,
                        input logic elast, input int ecnt, input logic eidle);
        tag++;
        req_valid     = v;
        req_last      = l;
        credit_return = r;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = mk(i, tag);
        #4;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(eov));
        if (eov) begin
            chk("out_src", 32'(out_src), 32'(esrc));
            chk("out_last", 32'(out_last), 32'(elast));
            chk("out_data", out_data, mk(int'(esrc), tag));
        end
        chk("credit_count", 32'(credit_count), 32'(ecnt));
        chk("idle", 32'(idle), 32'(eidle));
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        credit_return = 1'b0;

        // Single requester, 3-beat packet, then three credit returns
        add(1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 0, 23, 0);
        add(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 0, 22, 0);
        add(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 21, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 22, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 23, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 24, 1);
        // All four valid, single-beat packets: 0,1,2,3,0,1
        add(1, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 1, 23, 0);
        add(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 1, 22, 0);
        add(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 2, 1, 21, 0);
        add(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 3, 1, 20, 0);
        add(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 1, 19, 0);
        add(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 1, 18, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 18, 0);
        // Requester 0 4-beat packet blocks waiting requester 1
        add(1, 4'b0011, 4'b0010, 0, 4'b0001, 1, 0, 0, 23, 0);
        add(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 0, 0, 22, 0);
        add(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 0, 0, 21, 0);
        add(0, 4'b0011, 4'b0011, 0, 4'b0001, 1, 0, 1, 20, 0);
        add(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 19, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 19, 0);

        apply_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_credit_count", 32'(credit_count), 32'd24);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) apply_reset();
            step(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].er, tbl[i].eov,
                 tbl[i].esrc, tbl[i].elast, tbl[i].ecnt, tbl[i].eidle);
        end

        // Credit exhaustion and recovery by a single return
        apply_reset();
        for (int k = 0; k < 24; k++)
            step(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 23 - k, 0);
        step(4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 1, 0);
        step(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 0, 0);
        // Accept and return together at count 1
        step(4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 1, 0);
        step(4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 1, 1, 0);
        step(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 0, 0);

        // Return at full credit sets a sticky error
        apply_reset();
        chk("err_before", 32'(credit_err), 32'd0);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 24, 1);
        chk("err_set", 32'(credit_err), 32'd1);
        step(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 24, 1);
        step(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 23, 0);
        chk("err_sticky", 32'(credit_err), 32'd1);
        apply_reset();
        chk("err_cleared", 32'(credit_err), 32'd0);

        // Asynchronous reset while locked on requester 2
        step(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 0, 23, 0);
        step(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 0, 22, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_data", out_data, 32'd0);
        chk("mid_out_src", 32'(out_src), 32'd0);
        chk("mid_out_last", 32'(out_last), 32'd0);
        chk("mid_credit_count", 32'(credit_count), 32'd24);
        chk("mid_req_ready", 32'(req_ready), 32'd0);
        chk("mid_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        step(4'b0110, 4'b0010, 0, 4'b0010, 1, 1, 1, 23, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
